// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words into
// instruction memory and holds the core in reset until a load completes.
module prog_loader #(
  parameter int          DEPTH = 256,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] wordCount,
  input  logic        inValid,
  input  logic [7:0]  inByte,
  output logic        inReady,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic        cpuReset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  localparam logic [16:0] LIM = 17'(DEPTH);

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_wordIdx;
  logic [1:0]  r_byteIdx;
  logic [31:0] r_memAddr;
  logic [31:0] r_memData;
  logic        r_cpuReset;
  logic        r_err;

  logic w_tooBig;
  logic w_last;

  assign w_tooBig = {1'b0, wordCount} > LIM;
  assign w_last   = r_wordIdx == (r_count - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_wordIdx  <= '0;
      r_byteIdx  <= '0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_cpuReset <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (wordCount == 16'd0) begin
              r_cpuReset <= 1'b0;
              r_state    <= DONE;
            end else if (w_tooBig) begin
              r_err <= 1'b1;
            end else begin
              r_count    <= wordCount;
              r_wordIdx  <= '0;
              r_byteIdx  <= '0;
              r_cpuReset <= 1'b1;
              r_state    <= RECV;
            end
          end
        end
        RECV: begin
          if (inValid) begin
            r_memData[{r_byteIdx, 3'b000} +: 8] <= inByte;
            r_byteIdx <= r_byteIdx + 2'd1;
            if (r_byteIdx == 2'd3) begin
              // address is latched on entry so it is stable for the write
              r_memAddr <= BASE + {14'd0, r_wordIdx, 2'b00};
              r_state   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (w_last) begin
            r_cpuReset <= 1'b0;
            r_state    <= DONE;
          end else begin
            r_wordIdx <= r_wordIdx + 16'd1;
            r_state   <= RECV;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inReady  = r_state == RECV;
  assign memWe    = r_state == WRITE;
  assign busy     = (r_state == RECV) || (r_state == WRITE);
  assign done     = r_state == DONE;
  assign err      = r_err;
  assign memAddr  = r_memAddr;
  assign memData  = r_memData;
  assign cpuReset = r_cpuReset;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a word-list model predicts
// memory writes, busy time and done timing for each load.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] wordCount;
  logic        inValid;
  logic [7:0]  inByte;
  logic        inReady;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        cpuReset;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .wordCount(wordCount),
    .inValid(inValid), .inByte(inByte), .inReady(inReady),
    .memWe(memWe), .memAddr(memAddr), .memData(memData),
    .cpuReset(cpuReset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int busy_n, done_n, done_cyc, err_n;
  logic done_rst;
  logic [63:0] got[$];

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (memWe === 1'b1) got.push_back({memAddr, memData});
    if (busy === 1'b1) busy_n++;
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc_n;
      done_rst = cpuReset;
    end
    if (err === 1'b1) err_n++;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    got.delete();
    busy_n = 0;
    done_n = 0;
    err_n  = 0;
  endtask

  // One load of n words; model is simply the word list and 5 cycles/word.
  task automatic run_load(int n, bit stalls, bit noise, logic [31:0] w0);
    logic [31:0] words[$];
    int c, st;
    words.delete();
    words.push_back(w0);
    for (int i = 1; i < n; i++) words.push_back($urandom);
    clr();
    st = 0;
    c = cyc_n;
    start = 1'b1;
    wordCount = 16'(n);
    tick();
    start = 1'b0;
    chk("crst_load", {63'd0, cpuReset}, 64'd1);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (stalls && ($urandom % 4 == 0)) begin
          int k;
          k = $urandom_range(1, 7);
          inValid = 1'b0;
          for (int s = 0; s < k; s++) begin
            inByte = 8'($urandom);
            start = noise ? 1'($urandom) : 1'b0;
            wordCount = 16'($urandom);
            tick();
          end
          start = 1'b0;
          st += k;
        end
        inValid = 1'b1;
        inByte = words[i][8*b +: 8];
        start = noise ? 1'($urandom) : 1'b0;
        wordCount = 16'($urandom_range(1, 3));
        tick();
        start = 1'b0;
      end
      inValid = 1'($urandom);
      inByte = 8'($urandom);
      tick();
      inValid = 1'b0;
    end
    tick();
    for (int t = 0; t < 10 && done_n == 0; t++) tick();
    chk("done_n", 64'(done_n), 64'd1);
    chk("done_cyc", 64'(done_cyc), 64'(c + 5 * n + 1 + st));
    chk("done_crst", {63'd0, done_rst}, 64'd0);
    chk("busy_n", 64'(busy_n), 64'(5 * n + st));
    chk("nwr", 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk("wr", got[i], {32'(4 * i), words[i]});
    chk("crst_idle", {63'd0, cpuReset}, 64'd0);
  endtask

  task automatic bad_start(logic exp_crst);
    clr();
    start = 1'b1;
    wordCount = 16'd257;
    tick();
    start = 1'b0;
    chk("err_hi", {63'd0, err}, 64'd1);
    chk("err_busy", {62'd0, busy, inReady}, 64'd0);
    chk("err_crst", {63'd0, cpuReset}, {63'd0, exp_crst});
    tick();
    tick();
    chk("err_pulse", 64'(err_n), 64'd1);
    chk("err_idle", {61'd0, busy, done, memWe}, 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    wordCount = '0;
    inValid = 1'b0;
    inByte = '0;
    tick();
    tick();
    chk("rst_ctl", {58'd0, inReady, memWe, busy, done, err, cpuReset},
        64'd1);
    chk("rst_dat", {memAddr, memData}, 64'd0);
    reset = 1'b1;
    tick();

    bad_start(1'b1);
    run_load(1, 1'b0, 1'b0, 32'h0050_0013);
    bad_start(1'b0);
    run_load(3, 1'b0, 1'b0, $urandom);

    begin
      int c;
      clr();
      c = cyc_n;
      start = 1'b1;
      wordCount = 16'd0;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("wc0_done", 64'(done_n), 64'd1);
      chk("wc0_cyc", 64'(done_cyc), 64'(c + 1));
      chk("wc0_nwr", 64'(got.size()), 64'd0);
      chk("wc0_crst", {63'd0, cpuReset}, 64'd0);
    end

    for (int r = 0; r < 10; r++)
      run_load($urandom_range(1, 6), 1'b1, 1'b1, $urandom);

    start = 1'b1;
    wordCount = 16'd4;
    tick();
    start = 1'b0;
    for (int b = 0; b < 6; b++) begin
      inValid = 1'b1;
      inByte = 8'($urandom);
      tick();
      if (b == 3) begin
        inValid = 1'b0;
        tick();
      end
    end
    inValid = 1'b0;
    reset = 1'b0;
    tick();
    chk("mid_ctl", {59'd0, inReady, memWe, busy, done, cpuReset}, 64'd1);
    chk("mid_dat", {memAddr, memData}, 64'd0);
    reset = 1'b1;
    tick();
    bad_start(1'b1);
    run_load(1, 1'b0, 1'b0, $urandom);

    run_load(256, 1'b0, 1'b0, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
